// File: rtl/gcd_client.sv
// gcd_client: initiator-side sequencer for a subtractive GCD core.
//
// Accepts an operand pair on a valid/ready request port, screens out zero
// operands, starts the core, waits for it to finish (or times out), and returns
// the result on a valid/ready response port.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-low reset
//   req_valid  - request operand pair valid
//   req_ready  - block is idle and can accept a request
//   req_x/y    - request operands
//   gcd_x/y    - operands driven to the core
//   gcd_start  - one-cycle start pulse to the core
//   gcd_done   - core completion flag
//   gcd_result - core result
//   gcd_abort  - one-cycle pulse on timeout, ORed into the core reset
//   rsp_valid  - response valid
//   rsp_ready  - consumer accepts the response
//   rsp_gcd    - result (0 on error)
//   rsp_err    - zero operand or timeout
//   busy       - not idle
module gcd_client #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 255  // must be >= 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic [WIDTH-1:0] gcd_x,
  output logic [WIDTH-1:0] gcd_y,
  output logic             gcd_start,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             gcd_abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StArm,
    StWait,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [WIDTH-1:0]  rsp_gcd_q, rsp_gcd_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              start_q, start_d;
  logic              abort_q, abort_d;

  logic              timeout;
  logic [CntW-1:0]   cnt_inc;

  // Terminal count reached in this cycle; only acted on if the exit condition is absent.
  assign timeout = (cnt_q == CntW'(TIMEOUT - 1));
  // Saturating increment so the counter can never wrap back into range.
  assign cnt_inc = (cnt_q == CntW'(TIMEOUT)) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    rsp_gcd_d = rsp_gcd_q;
    rsp_err_d = rsp_err_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    abort_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          x_d = req_x;
          y_d = req_y;
          if (req_x == '0 || req_y == '0) begin
            // Zero operand would never terminate the subtractive core.
            rsp_gcd_d = '0;
            rsp_err_d = 1'b1;
            state_d   = StResp;
          end else begin
            start_d = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StArm;
      end
      StArm: begin
        cnt_d = cnt_inc;
        // DONE may still be high from the previous operation; wait for it to clear.
        if (!gcd_done) begin
          state_d = StWait;
        end else if (timeout) begin
          abort_d   = 1'b1;
          rsp_gcd_d = '0;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (gcd_done) begin
          rsp_gcd_d = gcd_result;
          rsp_err_d = 1'b0;
          state_d   = StResp;
        end else if (timeout) begin
          abort_d   = 1'b1;
          rsp_gcd_d = '0;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      rsp_gcd_q <= '0;
      rsp_err_q <= 1'b0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rsp_gcd_q <= rsp_gcd_d;
      rsp_err_q <= rsp_err_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_gcd   = rsp_gcd_q;
  assign rsp_err   = rsp_err_q;
  assign gcd_x     = x_q;
  assign gcd_y     = y_q;
  assign gcd_start = start_q;
  assign gcd_abort = abort_q;

endmodule

// File: tb/tb_gcd_client.sv
// Self-checking bench for gcd_client: behavioural GCD core, transaction-level
// expectation model, per-cycle compare process, directed and random stimulus.
module tb_gcd_client;
  localparam int unsigned W  = 8;
  localparam int unsigned TO = 16;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_x;
  logic [W-1:0] req_y;
  logic [W-1:0] gcd_x;
  logic [W-1:0] gcd_y;
  logic         gcd_start;
  logic         gcd_done;
  logic [W-1:0] gcd_result;
  logic         gcd_abort;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_gcd;
  logic         rsp_err;
  logic         busy;

  gcd_client #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .gcd_x      (gcd_x),
    .gcd_y      (gcd_y),
    .gcd_start  (gcd_start),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .gcd_abort  (gcd_abort),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_gcd    (rsp_gcd),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = b;
      b = a % b;
      a = t;
    end
    return a;
  endfunction

  // Core behaviour knobs, changed only while the client is idle.
  int drop_lag   = 1;  // cycles after START until DONE drops
  int rise_lag   = 5;  // cycles after the drop until DONE rises
  bit dead       = 0;  // core never finishes
  bit ready_rand = 0;

  // Behavioural core: DONE is held high after completion until the next start.
  bit core_active = 0;
  int core_age = 0, cx = 0, cy = 0, sgx = 0, sgy = 0;
  bit s_st = 0, s_ab = 0, s_rs = 0;
  initial begin
    gcd_done   = 1'b0;
    gcd_result = '0;
    forever begin
      @(negedge clk);
      s_st = gcd_start; s_ab = gcd_abort; s_rs = reset; sgx = gcd_x; sgy = gcd_y;
      @(posedge clk);
      #1;
      if (!s_rs || s_ab) begin
        core_active = 0;
        gcd_done    = 1'b0;
      end else if (s_st) begin
        core_active = 1; core_age = 1; cx = sgx; cy = sgy;
        if (drop_lag == 1) gcd_done = 1'b0;
      end else if (core_active) begin
        core_age++;
        if (core_age == drop_lag) gcd_done = 1'b0;
        if (!dead && core_age == drop_lag + rise_lag) begin
          gcd_done    = 1'b1;
          gcd_result  = W'(gcd_ref(cx, cy));
          core_active = 0;
        end
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Expected response per accepted request, from the operands and core behaviour.
  typedef struct {
    int gcd;
    int err;
    int abort;
    int lat;  // cycles from acceptance edge to first rsp_valid cycle
    int acc;
  } exp_t;
  exp_t exp_q[$];
  int   log_gcd[$];
  int   log_err[$];
  int   start_cnt = 0, abort_cnt = 0, cyc = 0;
  bit   start_due = 0, prev_rv = 0, prev_hs = 0, zero = 0;
  int   sx = 0, sy = 0;
  exp_t e;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        exp_q.delete();
        start_due = 0; prev_rv = 0; prev_hs = 0;
        continue;
      end
      if (gcd_start) start_cnt++;
      if (gcd_abort) abort_cnt++;
      chk("req_ready_vs_busy", req_ready, !busy);
      chk("start_abort_excl", gcd_start & gcd_abort, 0);
      chk("start_timing", gcd_start, start_due);
      if (start_due) begin
        chk("gcd_x", gcd_x, sx);
        chk("gcd_y", gcd_y, sy);
      end
      if (prev_hs) begin
        chk("rsp_drop_after_hs", rsp_valid, 0);
        chk("req_ready_after_hs", req_ready, 1);
      end
      prev_hs = 0;
      if (rsp_valid) begin
        chk("req_ready_in_resp", req_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", exp_q.size(), 1);
        end else begin
          e = exp_q[0];
          chk("rsp_gcd", rsp_gcd, e.gcd);
          chk("rsp_err", rsp_err, e.err);
          if (!prev_rv) begin
            chk("abort_at_resp", gcd_abort, e.abort);
            chk("latency", cyc - e.acc, e.lat);
          end else begin
            chk("abort_single", gcd_abort, 0);
          end
          if (rsp_ready) begin
            log_gcd.push_back(int'(rsp_gcd));
            log_err.push_back(int'(rsp_err));
            void'(exp_q.pop_front());
            prev_hs = 1;
          end
        end
      end else begin
        chk("abort_outside_resp", gcd_abort, 0);
      end
      prev_rv   = rsp_valid;
      start_due = 0;
      if (req_valid && req_ready) begin
        zero    = (req_x == 0 || req_y == 0);
        e.gcd   = (zero || dead) ? 0 : gcd_ref(int'(req_x), int'(req_y));
        e.err   = (zero || dead) ? 1 : 0;
        e.abort = (!zero && dead) ? 1 : 0;
        e.lat   = zero ? 1 : (dead ? int'(TO) + 2 : drop_lag + rise_lag + 2);
        e.acc   = cyc;
        exp_q.push_back(e);
        start_due = !zero;
        sx = int'(req_x);
        sy = int'(req_y);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y);
    int n;
    n = 0;
    req_x = W'(x); req_y = W'(y); req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_accept_bound", 0, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("drain_bound", 0, 1);
  endtask

  task automatic chk_last(input string name, input int base, input int g, input int er);
    chk({name, "_count"}, log_gcd.size(), base + 1);
    if (log_gcd.size() == base + 1) begin
      chk({name, "_gcd"}, log_gcd[base], g);
      chk({name, "_err"}, log_err[base], er);
    end
  endtask

  int base, s0, a0, x, y;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0;
    repeat (3) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_start", gcd_start, 0);
    chk("rst_abort", gcd_abort, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_gcd", rsp_gcd, 0);
    chk("rst_rsp_err", rsp_err, 0);
    tick();

    // 12,8 with DONE low one cycle after START, high five cycles later.
    drop_lag = 1; rise_lag = 5;
    base = log_gcd.size(); s0 = start_cnt;
    send(12, 8);
    wait_idle();
    chk_last("t12_8", base, 4, 0);
    chk("t12_8_starts", start_cnt - s0, 1);

    // Zero operands never start the core.
    s0 = start_cnt;
    base = log_gcd.size();
    send(0, 5);
    wait_idle();
    chk_last("t0_5", base, 0, 1);
    base = log_gcd.size();
    send(7, 0);
    wait_idle();
    chk_last("t7_0", base, 0, 1);
    chk("zero_starts", start_cnt - s0, 0);

    // DONE still high from 12,8 (stale result 4): must wait for drop and re-rise.
    drop_lag = 3; rise_lag = 2;
    base = log_gcd.size();
    send(9, 6);
    wait_idle();
    chk_last("t9_6", base, 3, 0);

    // Dead core: timeout and a single abort pulse.
    dead = 1; drop_lag = 1; rise_lag = 1;
    base = log_gcd.size(); a0 = abort_cnt;
    send(11, 7);
    wait_idle();
    chk_last("t_dead", base, 0, 1);
    chk("dead_aborts", abort_cnt - a0, 1);
    dead = 0;

    // Back-to-back with random response back-pressure.
    drop_lag = 1; rise_lag = 3; ready_rand = 1;
    base = log_gcd.size();
    send(15, 10);
    send(14, 21);
    send(13, 13);
    wait_idle();
    ready_rand = 0;
    chk("b2b_count", log_gcd.size(), base + 3);
    if (log_gcd.size() == base + 3) begin
      chk("b2b_0", log_gcd[base], 5);
      chk("b2b_1", log_gcd[base + 1], 7);
      chk("b2b_2", log_gcd[base + 2], 13);
    end

    // Reset while waiting on the core.
    drop_lag = 1; rise_lag = 6;
    base = log_gcd.size(); a0 = abort_cnt;
    send(8, 4);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_abort", gcd_abort, 0);
    tick();
    chk("mid_rst_no_rsp", log_gcd.size(), base);
    chk("mid_rst_no_abort", abort_cnt - a0, 0);
    drop_lag = 1; rise_lag = 2;
    send(8, 4);
    wait_idle();
    chk_last("t8_4", base, 4, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      wait_idle();
      dead       = ($urandom_range(0, 9) == 0);
      drop_lag   = $urandom_range(1, 3);
      rise_lag   = $urandom_range(1, 6);
      ready_rand = 1;
      x = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 255);
      y = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 255);
      repeat ($urandom_range(0, 2)) tick();
      send(x, y);
      if ($urandom_range(0, 2) == 0) begin
        // Requests presented while busy must be ignored until idle.
        req_x = W'($urandom_range(1, 255));
        req_y = W'($urandom_range(1, 255));
        req_valid = 1'b1;
        repeat (2) tick();
        req_valid = 1'b0;
      end
    end
    wait_idle();
    ready_rand = 0;
    dead = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
